// File: rtl/vga_grid_capture.sv
// Receive side of the 32x32 grid VGA pattern: rebuilds raster position from the
// sync edges and writes the centre sample of every grid cell into a capture RAM.
module vga_grid_capture #(
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int H_SYNC_END = 751,
    parameter int V_SYNC_END = 491,
    parameter int X0         = 80,
    parameter int Y0         = 0,
    parameter int CELL       = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [14:0] rgb,
    output logic        cap_we,
    output logic [9:0]  cap_addr,
    output logic [14:0] cap_data,
    output logic        locked,
    output logic        frame_done,
    output logic [7:0]  sync_err
);
    localparam int HW   = $clog2(H_TOTAL);
    localparam int VW   = $clog2(V_TOTAL);
    localparam int SW   = $clog2(CELL);
    localparam int GRID = 32 * CELL;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_EDGE = HW'(H_SYNC_END + 1);
    localparam logic [HW-1:0] H_X0   = HW'(X0);
    localparam logic [HW-1:0] H_GRID = HW'(GRID);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_EDGE = VW'(V_SYNC_END + 1);
    localparam logic [VW-1:0] V_Y0   = VW'(Y0);
    localparam logic [VW-1:0] V_GRID = VW'(GRID);
    localparam logic [SW-1:0] S_LAST = SW'(CELL - 1);
    localparam logic [SW-1:0] S_MID  = SW'(CELL / 2);

    typedef enum logic [1:0] {UNLOCKED, HLOCK, LOCKED} state_t;

    state_t          state_q, state_d;
    logic            hs_q, vs_q, hs_p_q, vs_p_q;
    logic [14:0]     rgb_q;
    logic [HW-1:0]   hcnt_q, hcnt_d, h_pred;
    logic [VW-1:0]   vcnt_q, vcnt_d, v_pred;
    logic [SW-1:0]   subx_q, subx_d, suby_q, suby_d;
    logic [4:0]      col_q, col_d, row_q, row_d;
    logic [1:0]      hmatch_q, hmatch_d;
    logic [7:0]      err_q, err_d;
    logic            cap_we_q, cap_we_d, locked_q, locked_d, fdone_q, fdone_d;
    logic [9:0]      cap_addr_q, cap_addr_d;
    logic [14:0]     cap_data_q, cap_data_d;
    logic            hs_rise, vs_rise, line_st, h_bad, v_bad, err_c, in_grid;

    // hcnt_q/vcnt_q hold the position of the previous sample; *_d is the
    // position of the sample currently sitting in the input registers.
    always_comb begin
        hs_rise = hs_q & ~hs_p_q;
        vs_rise = vs_q & ~vs_p_q;
        h_pred  = (hcnt_q == H_LAST) ? '0 : hcnt_q + 1'b1;
        hcnt_d  = hs_rise ? H_EDGE : h_pred;
        line_st = (hcnt_d == '0);
        v_pred  = vcnt_q;
        if (line_st)
            v_pred = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        vcnt_d  = (vs_rise && line_st) ? V_EDGE : v_pred;
        h_bad   = hs_rise && (h_pred != H_EDGE);
        v_bad   = vs_rise && (!line_st || v_pred != V_EDGE);

        state_d  = state_q;
        hmatch_d = hmatch_q;
        err_c    = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (hs_rise) begin
                    state_d  = HLOCK;
                    hmatch_d = '0;
                end
            end
            HLOCK: begin
                err_c = h_bad;
                if (hs_rise && hmatch_q != 2'd2)
                    hmatch_d = hmatch_q + 1'b1;
                if (vs_rise && line_st && hmatch_q == 2'd2)
                    state_d = LOCKED;
            end
            LOCKED:  err_c = h_bad || v_bad;
            default: state_d = UNLOCKED;
        endcase
        // simultaneous h and v mismatches still count as a single error
        if (err_c)
            state_d = UNLOCKED;
        err_d    = (err_c && err_q != 8'hFF) ? err_q + 1'b1 : err_q;
        locked_d = (state_d == LOCKED);

        subx_d = subx_q + 1'b1;
        col_d  = col_q;
        if (hcnt_d == H_X0) begin
            subx_d = '0;
            col_d  = '0;
        end else if (subx_q == S_LAST) begin
            subx_d = '0;
            col_d  = col_q + 1'b1;
        end

        suby_d = suby_q;
        row_d  = row_q;
        if (line_st) begin
            if (vcnt_d == V_Y0) begin
                suby_d = '0;
                row_d  = '0;
            end else if (suby_q == S_LAST) begin
                suby_d = '0;
                row_d  = row_q + 1'b1;
            end else begin
                suby_d = suby_q + 1'b1;
            end
        end

        // unsigned wrap keeps positions left of/above the grid out of range
        in_grid    = ((hcnt_d - H_X0) < H_GRID) && ((vcnt_d - V_Y0) < V_GRID);
        cap_we_d   = (state_q == LOCKED) && !err_c && in_grid &&
                     (subx_d == S_MID) && (suby_d == S_MID);
        cap_addr_d = cap_we_d ? {row_d, col_d} : cap_addr_q;
        cap_data_d = cap_we_d ? rgb_q : cap_data_q;
        fdone_d    = cap_we_q && (cap_addr_q == 10'h3FF);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            hs_p_q     <= 1'b1;
            vs_p_q     <= 1'b1;
            rgb_q      <= '0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            subx_q     <= '0;
            suby_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            state_q    <= UNLOCKED;
            hmatch_q   <= '0;
            err_q      <= '0;
            locked_q   <= 1'b0;
            cap_we_q   <= 1'b0;
            cap_addr_q <= '0;
            cap_data_q <= '0;
            fdone_q    <= 1'b0;
        end else begin
            hs_q       <= hsync;
            vs_q       <= vsync;
            hs_p_q     <= hs_q;
            vs_p_q     <= vs_q;
            rgb_q      <= rgb;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            subx_q     <= subx_d;
            suby_q     <= suby_d;
            col_q      <= col_d;
            row_q      <= row_d;
            state_q    <= state_d;
            hmatch_q   <= hmatch_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
            cap_we_q   <= cap_we_d;
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            fdone_q    <= fdone_d;
        end
    end

    assign cap_we     = cap_we_q;
    assign cap_addr   = cap_addr_q;
    assign cap_data   = cap_data_q;
    assign locked     = locked_q;
    assign frame_done = fdone_q;
    assign sync_err   = err_q;
endmodule
